trap_controller: RTL
====================

# trap_controller

Machine-mode trap controller for the RV64 pipeline. It collects exception requests from ID (illegal opcode), EX (misaligned control-flow target) and MEM (load/store access fault), and selects the oldest one. It drives the 3-bit `trap_type` code consumed by the flush and exception-PC logic, and supplies the redirect PC. It also holds `mepc`, `mcause`, `mtval`, `mtvec` and the trap state machine, and completes `mret` by redirecting to `mepc`.

## Interface
Parameters:
- `XLEN`, 64, data/address width
- `MTVEC_RESET`, 64'h0000_0000_0000_0100, reset value of `mtvec`

Ports. One clock; reset is synchronous and active-high.
- `clk` in 1, the single clock
- `rst` in 1, synchronous active-high reset
- `illegal_opcode_id` in 1, ID-stage illegal opcode
- `pc_id` in XLEN, PC of the ID instruction
- `misalign_ex` in 1, EX jump/branch target not 4-byte aligned
- `pc_ex` in XLEN, PC of the EX instruction
- `target_ex` in XLEN, the offending target
- `mem_fault_mem` in 1, MEM access fault
- `mem_is_store` in 1, the faulting MEM access is a store
- `pc_mem` in XLEN, PC of the MEM instruction
- `fault_addr_mem` in XLEN, the faulting address
- `exception_ret` in 1, mret decoded in ID
- `csr_we` in 1, CSR write strobe
- `csr_addr` in 12, CSR address
- `csr_wdata` in XLEN, CSR write data
- `trap_type` out 3: 000 none, 001 MEM trap, 010 EX trap, 011 ID trap
- `trap_pc` out XLEN, redirect PC, valid when `trap_type`≠000 or an mret is accepted
- `mepc`, `mcause`, `mtval`, `mtvec` out XLEN each, CSR contents
- `in_trap` out 1, high while in the handler
- `double_fault` out 1, sticky flag
- `trap_count` out 32, traps taken, saturating

## Operation
- Priority encoding:
  - MEM fault gives 001.
  - Otherwise an EX misalign gives 010.
  - Otherwise an ID illegal opcode gives 011.
  - Otherwise 000.
  - Older stage always wins.
- Requests are honoured only in state IDLE. In HANDLER, any request is masked (`trap_type`=000), sets `double_fault`, and causes no state or CSR change.
- States:
  - IDLE→HANDLER on any honoured request.
  - HANDLER→IDLE on `exception_ret`.
  - No other transitions.
- On a trap, `trap_pc`=`mtvec` with bits[1:0] forced to 0. At the next edge, CSRs capture:
  - MEM: `mepc`=`pc_mem`; `mcause`=7 if a store, 5 if a load; `mtval`=`fault_addr_mem`.
  - EX: `mepc`=`pc_ex`; `mcause`=0; `mtval`=`target_ex`.
  - ID: `mepc`=`pc_id`; `mcause`=2; `mtval`=0.
- mret: when `exception_ret`=1 and no honoured trap is present that cycle:
  - `trap_pc`=`mepc`.
  - The state returns to IDLE; mret in IDLE also redirects, with no state change.
- mret coinciding with an honoured EX/MEM trap: the trap wins and the mret is dropped, since the mret instruction is flushed.
- CSR writes:
  - 0x305 writes `mtvec`.
  - 0x341 writes `mepc` with bits[1:0] cleared.
  - 0x342 writes `mcause`.
  - 0x343 writes `mtval`.
  - Other addresses are ignored.
  - A trap capture in the same cycle overrides the CSR write for `mepc`/`mcause`/`mtval`.
- `trap_count` increments on each honoured trap and holds at 32'hFFFF_FFFF.

## Timing
- `trap_type` and `trap_pc` are combinational from the same-cycle inputs and state, with zero latency. The flush and PC-select logic act in the same cycle.
- State, CSRs, `in_trap` and `trap_count` update at the `clk` edge after the request.
- `in_trap` rises the cycle after the trap and falls the cycle after an accepted mret.
- Reset (synchronous, overrides everything, including mid-handler):
  - state IDLE, `in_trap`=0, `double_fault`=0.
  - `mepc`=`mcause`=`mtval`=0, `mtvec`=`MTVEC_RESET`, `trap_count`=0.
  - During `rst`: `trap_type`=000, `trap_pc`=0.
- A request held across many cycles traps once; the remaining cycles count as masked.

## Structure
- `trap_pkg` holds:
  - the `trap_type` encodings (TRAP_NONE/MEM/EX/ID);
  - the mcause constants (0, 2, 5, 7);
  - the CSR addresses (0x305, 0x341–0x343);
  - the state enum (IDLE, HANDLER).
- Sub-module `trap_priority_enc`: combinational. It maps the three requests to `trap_type` plus the selected epc/cause/tval.

## Test plan
- Reset, then `illegal_opcode_id`=1 with `pc_id`=0x80 → `trap_type`=011 and `trap_pc`=0x100 in the same cycle. Next cycle: `mepc`=0x80, `mcause`=2, `in_trap`=1, `trap_count`=1.
- `mem_fault_mem`=1 (store, addr 0x2003, `pc_mem`=0x40) together with `misalign_ex`=1 → `trap_type`=001. Next cycle: `mepc`=0x40, `mcause`=7, `mtval`=0x2003.
- In HANDLER, `exception_ret`=1 → `trap_pc`=`mepc`. Next cycle `in_trap`=0; a following ID illegal opcode traps again.
- In HANDLER, `misalign_ex`=1 → `trap_type`=000, `double_fault`=1 (sticky), `mepc` unchanged.
- `csr_we` to 0x305 with 0x203 → `mtvec`=0x203; the next trap has `trap_pc`=0x200. A CSR write to 0x341 in the same cycle as a trap → the trap value is kept.
- `rst` asserted while in HANDLER → next cycle all outputs are at their reset values and `mtvec`=0x100.

Source files
------------

// File: rtl/trap_pkg.sv
// Shared encodings for the machine-mode trap controller: trap codes, mcause values,
// CSR addresses and the trap state machine states.
package trap_pkg;

    typedef enum logic [2:0] {
        TRAP_NONE = 3'b000,
        TRAP_MEM  = 3'b001,
        TRAP_EX   = 3'b010,
        TRAP_ID   = 3'b011
    } trap_type_e;

    localparam logic [3:0] MCAUSE_INSN_MISALIGN = 4'd0;
    localparam logic [3:0] MCAUSE_ILLEGAL_INSN  = 4'd2;
    localparam logic [3:0] MCAUSE_LOAD_FAULT    = 4'd5;
    localparam logic [3:0] MCAUSE_STORE_FAULT   = 4'd7;

    localparam logic [11:0] CSR_MTVEC  = 12'h305;
    localparam logic [11:0] CSR_MEPC   = 12'h341;
    localparam logic [11:0] CSR_MCAUSE = 12'h342;
    localparam logic [11:0] CSR_MTVAL  = 12'h343;

    typedef enum logic {
        IDLE    = 1'b0,
        HANDLER = 1'b1
    } trap_state_e;

endpackage

// File: rtl/trap_priority_enc.sv
// Oldest-stage-wins selection among MEM, EX and ID exception requests, producing the
// trap code together with the epc/cause/tval that the selected request would record.
module trap_priority_enc
    import trap_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic            illegal_opcode_id,
    input  logic [XLEN-1:0] pc_id,
    input  logic            misalign_ex,
    input  logic [XLEN-1:0] pc_ex,
    input  logic [XLEN-1:0] target_ex,
    input  logic            mem_fault_mem,
    input  logic            mem_is_store,
    input  logic [XLEN-1:0] pc_mem,
    input  logic [XLEN-1:0] fault_addr_mem,
    output logic [2:0]      sel_type,
    output logic [XLEN-1:0] sel_epc,
    output logic [XLEN-1:0] sel_cause,
    output logic [XLEN-1:0] sel_tval
);

    always_comb begin
        sel_type  = TRAP_NONE;
        sel_epc   = '0;
        sel_cause = '0;
        sel_tval  = '0;
        if (mem_fault_mem) begin
            sel_type  = TRAP_MEM;
            sel_epc   = pc_mem;
            sel_cause = mem_is_store ? XLEN'(MCAUSE_STORE_FAULT) : XLEN'(MCAUSE_LOAD_FAULT);
            sel_tval  = fault_addr_mem;
        end else if (misalign_ex) begin
            sel_type  = TRAP_EX;
            sel_epc   = pc_ex;
            sel_cause = XLEN'(MCAUSE_INSN_MISALIGN);
            sel_tval  = target_ex;
        end else if (illegal_opcode_id) begin
            sel_type  = TRAP_ID;
            sel_epc   = pc_id;
            sel_cause = XLEN'(MCAUSE_ILLEGAL_INSN);
            sel_tval  = '0;
        end
    end

endmodule

// File: rtl/trap_controller.sv
// Machine-mode trap controller: selects the oldest exception, redirects to mtvec or mepc,
// and owns the trap CSRs, handler state, double-fault flag and trap counter.
module trap_controller
    import trap_pkg::*;
#(
    parameter int              XLEN        = 64,
    parameter logic [XLEN-1:0] MTVEC_RESET = 64'h0000_0000_0000_0100
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            illegal_opcode_id,
    input  logic [XLEN-1:0] pc_id,
    input  logic            misalign_ex,
    input  logic [XLEN-1:0] pc_ex,
    input  logic [XLEN-1:0] target_ex,
    input  logic            mem_fault_mem,
    input  logic            mem_is_store,
    input  logic [XLEN-1:0] pc_mem,
    input  logic [XLEN-1:0] fault_addr_mem,
    input  logic            exception_ret,
    input  logic            csr_we,
    input  logic [11:0]     csr_addr,
    input  logic [XLEN-1:0] csr_wdata,
    output logic [2:0]      trap_type,
    output logic [XLEN-1:0] trap_pc,
    output logic [XLEN-1:0] mepc,
    output logic [XLEN-1:0] mcause,
    output logic [XLEN-1:0] mtval,
    output logic [XLEN-1:0] mtvec,
    output logic            in_trap,
    output logic            double_fault,
    output logic [31:0]     trap_count
);

    trap_state_e     state;
    logic [2:0]      enc_type;
    logic [XLEN-1:0] enc_epc;
    logic [XLEN-1:0] enc_cause;
    logic [XLEN-1:0] enc_tval;
    logic            req_any;
    logic            honoured;
    logic            masked;
    logic            mret_ok;

    trap_priority_enc #(.XLEN(XLEN)) u_prio (
        .illegal_opcode_id (illegal_opcode_id),
        .pc_id             (pc_id),
        .misalign_ex       (misalign_ex),
        .pc_ex             (pc_ex),
        .target_ex         (target_ex),
        .mem_fault_mem     (mem_fault_mem),
        .mem_is_store      (mem_is_store),
        .pc_mem            (pc_mem),
        .fault_addr_mem    (fault_addr_mem),
        .sel_type          (enc_type),
        .sel_epc           (enc_epc),
        .sel_cause         (enc_cause),
        .sel_tval          (enc_tval)
    );

    assign req_any  = (enc_type != TRAP_NONE);
    assign honoured = !rst && req_any && (state == IDLE);
    assign masked   = !rst && req_any && (state == HANDLER);
    // An honoured trap flushes the mret instruction, so the trap takes the redirect.
    assign mret_ok  = !rst && exception_ret && !honoured;

    always_comb begin
        trap_type = TRAP_NONE;
        trap_pc   = '0;
        if (honoured) begin
            trap_type = enc_type;
            trap_pc   = {mtvec[XLEN-1:2], 2'b00};
        end else if (mret_ok) begin
            trap_pc = mepc;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            in_trap      <= 1'b0;
            double_fault <= 1'b0;
            mepc         <= '0;
            mcause       <= '0;
            mtval        <= '0;
            mtvec        <= MTVEC_RESET;
            trap_count   <= '0;
        end else begin
            if (csr_we) begin
                case (csr_addr)
                    CSR_MTVEC:  mtvec  <= csr_wdata;
                    CSR_MEPC:   mepc   <= {csr_wdata[XLEN-1:2], 2'b00};
                    CSR_MCAUSE: mcause <= csr_wdata;
                    CSR_MTVAL:  mtval  <= csr_wdata;
                    default:    ;
                endcase
            end
            // Trap capture comes after the CSR write so it takes precedence.
            if (honoured) begin
                state   <= HANDLER;
                in_trap <= 1'b1;
                mepc    <= enc_epc;
                mcause  <= enc_cause;
                mtval   <= enc_tval;
                if (trap_count != 32'hFFFF_FFFF)
                    trap_count <= trap_count + 32'd1;
            end else if (mret_ok) begin
                state   <= IDLE;
                in_trap <= 1'b0;
            end
            if (masked)
                double_fault <= 1'b1;
        end
    end

endmodule
